// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions used by the fetch path.
package rv32i_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int ctr_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Up-counter for cycles spent waiting on an instruction memory acknowledge.
module fetch_timeout_ctr
    import rv32i_pkg::*;
#(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = ctr_width(MAX);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(MAX));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch controller: issues imem requests at pc, holds the word for decode,
// strobes the PC load and latches misaligned / timeout faults.
//
//   state | meaning
//   IDLE  | one cycle after reset release
//   FETCH | request outstanding at pc (or fault check on misaligned pc)
//   VALID | instr held for decode, waiting on instr_ready
//   FAULT | sticky fault, left only by reset
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter int          TIMEOUT     = 15,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        pc_load,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] FETCH = ST_FETCH;
    localparam logic [1:0] VALID = ST_VALID;
    localparam logic [1:0] FAULT = ST_FAULT;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       aligned;
    logic       req_active;
    logic       ack_take;
    logic       ctr_tc;
    logic       timeout_hit;

    assign aligned    = (pc[1:0] == 2'b00);
    assign req_active = (state == FETCH) && aligned;
    assign ack_take   = req_active && imem_ack;
    // an ack in the terminal-count cycle still completes the fetch
    assign timeout_hit = req_active && !imem_ack && ctr_tc && (TIMEOUT != 0);

    fetch_timeout_ctr #(
        .MAX (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (!req_active || imem_ack),
        .en    (req_active && !imem_ack && (TIMEOUT != 0)),
        .tc    (ctr_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (!aligned) begin
                    state_nxt = FAULT;
                end else if (imem_ack) begin
                    state_nxt = VALID;
                end else if (timeout_hit) begin
                    state_nxt = FAULT;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    state_nxt = FETCH;
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_cause <= FC_NONE;
        end else if (state == FETCH) begin
            if (!aligned) begin
                fault_cause <= FC_MISALIGN;
            end else if (timeout_hit) begin
                fault_cause <= FC_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr       <= RESET_INSTR;
            instr_valid <= 1'b0;
        end else if (ack_take) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
        end else if ((state == VALID) && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

    assign imem_req    = req_active;
    assign imem_addr   = pc;
    assign pc_load     = (state == VALID) && instr_ready;
    assign fetch_fault = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against transaction-level expectations.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_load;
    logic        fetch_fault;
    logic [1:0]  fault_cause;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_instr;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_load     (pc_load),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk1({tag, "_valid"}, instr_valid, 1'b0);
        chk1({tag, "_load"}, pc_load, 1'b0);
        chk32({tag, "_instr"}, instr, 32'h0000_0013);
        chk1({tag, "_fault"}, fetch_fault, 1'b0);
        chk32({tag, "_cause"}, {30'b0, fault_cause}, 32'd0);
    endtask

    // Memory answers after `waits` unacknowledged request cycles.
    task automatic req_phase(input int waits, input logic [31:0] data);
        for (int i = 0; i <= waits; i++) begin
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? data : $urandom;
            @(negedge clk);
            chk1("req_high", imem_req, 1'b1);
            chk32("req_addr", imem_addr, pc);
            chk1("req_noload", pc_load, 1'b0);
            chk1("req_novalid", instr_valid, 1'b0);
            chk1("req_nofault", fetch_fault, 1'b0);
            next_cycle();
        end
        imem_ack = 1'b0;
    endtask

    // Decode stalls for `stall` cycles (with spurious acks) then accepts.
    task automatic valid_phase(input int stall, input logic [31:0] data);
        for (int s = 0; s <= stall; s++) begin
            instr_ready = (s == stall);
            imem_ack    = (s != stall) && ($urandom_range(0, 1) == 1);
            imem_rdata  = $urandom;
            @(negedge clk);
            chk32("valid_instr", instr, data);
            chk1("valid_flag", instr_valid, 1'b1);
            chk1("valid_noreq", imem_req, 1'b0);
            chk1("valid_load", pc_load, (s == stall));
            chk1("valid_nofault", fetch_fault, 1'b0);
            next_cycle();
        end
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        pc          = pc + 32'd4;
        last_instr  = data;
    endtask

    task automatic fetch_one(input int waits, input int stall, input logic [31:0] data);
        req_phase(waits, data);
        valid_phase(stall, data);
    endtask

    task automatic fault_hold(input int n, input logic [1:0] cause);
        for (int i = 0; i < n; i++) begin
            imem_ack   = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            @(negedge clk);
            chk1("fault_flag", fetch_fault, 1'b1);
            chk32("fault_cause", {30'b0, fault_cause}, {30'b0, cause});
            chk1("fault_noreq", imem_req, 1'b0);
            chk1("fault_novalid", instr_valid, 1'b0);
            chk1("fault_noload", pc_load, 1'b0);
            chk32("fault_instr", instr, last_instr);
            next_cycle();
        end
        imem_ack = 1'b0;
    endtask

    // Release reset just after an edge; one IDLE cycle follows.
    task automatic restart();
        next_cycle();
        reset = 1'b1;
        pc    = 32'd0;
        @(negedge clk);
        chk1("idle_noreq", imem_req, 1'b0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset       = 1'b0;
        pc          = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        last_instr  = 32'h0000_0013;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outputs("por");

        restart();
        fetch_one(0, 0, 32'h0050_0093);

        d = $urandom;
        fetch_one(3, 5, d);

        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            fetch_one($urandom_range(0, 15), $urandom_range(0, 4), d);
        end

        // ack lands exactly on the terminal count
        d = $urandom;
        fetch_one(15, 1, d);

        for (int i = 0; i < 16; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk1("to_req", imem_req, 1'b1);
            chk1("to_nofault", fetch_fault, 1'b0);
            next_cycle();
        end
        fault_hold(4, 2'b10);

        reset = 1'b0;
        #1;
        chk_reset_outputs("rst_fault");
        restart();

        imem_ack = 1'b0;
        @(negedge clk);
        chk1("rf_req_pre", imem_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("rst_fetch");
        restart();
        d = $urandom;
        fetch_one(2, 0, d);

        d = $urandom;
        req_phase(1, d);
        instr_ready = 1'b1;
        @(negedge clk);
        chk1("rv_valid_pre", instr_valid, 1'b1);
        chk1("rv_load_pre", pc_load, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("rst_valid");
        instr_ready = 1'b0;
        restart();
        d = $urandom;
        fetch_one(0, 2, d);

        pc       = 32'h0000_0006;
        imem_ack = 1'b1;
        @(negedge clk);
        chk1("mis_noreq", imem_req, 1'b0);
        chk1("mis_nofault_yet", fetch_fault, 1'b0);
        next_cycle();
        fault_hold(5, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
